// File: rtl/ram_init_ctrl_if.sv
// Byte-stream handshake between an image source and the RAM init controller.
// The source drives valid/data; the controller answers with ready.
interface ram_init_ctrl_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ram_init_ctrl.sv
// RAM image loader: takes a 16-bit little-endian length header and a byte stream,
// writes the bytes from address 0, then hands the RAM port over to the CPU.
module ram_init_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    ram_init_ctrl_if.slave    s_if,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_gnt,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        LOAD   = 3'd3,
        FLUSH  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_e;

    localparam logic [16:0] DEPTH_17 = 17'(DEPTH);

    state_e            state_q, state_d;
    logic [15:0]       len_q;
    logic [15:0]       cnt_q;
    logic [ADDR_W:0]   waddr_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        ram_wdata_q;
    logic              ram_we_q;

    logic              in_ready_s;
    logic              hs_s;
    logic [15:0]       len_hdr_s;
    logic              wr_ok_s;

    assign in_ready_s = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == LOAD);
    assign hs_s       = s_if.in_valid && in_ready_s;
    assign len_hdr_s  = {s_if.in_data, len_q[7:0]};
    // Extra guard so a corrupted count can never push the address past len.
    assign wr_ok_s    = (17'(waddr_q) < {1'b0, len_q});

    assign s_if.in_ready = in_ready_s;
    assign busy      = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       (state_q == LOAD)   || (state_q == FLUSH);
    assign done      = (state_q == DONE);
    assign cpu_gnt   = (state_q == DONE);
    assign err       = (state_q == ERROR);
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_addr  = (state_q == DONE) ? cpu_addr : ram_addr_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LEN_LO;
                else       state_d = IDLE;
            end
            LEN_LO: begin
                if (hs_s) state_d = LEN_HI;
                else      state_d = LEN_LO;
            end
            LEN_HI: begin
                if (!hs_s)                             state_d = LEN_HI;
                else if (len_hdr_s == 16'd0)           state_d = FLUSH;
                else if ({1'b0, len_hdr_s} > DEPTH_17) state_d = ERROR;
                else                                   state_d = LOAD;
            end
            LOAD: begin
                if (hs_s && (cnt_q == 16'd1)) state_d = FLUSH;
                else                          state_d = LOAD;
            end
            FLUSH: state_d = DONE;
            DONE: begin
                if (start) state_d = LEN_LO;
                else       state_d = DONE;
            end
            ERROR: begin
                if (start) state_d = LEN_LO;
                else       state_d = ERROR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Header capture, write counters and the registered RAM write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q       <= 16'd0;
            cnt_q       <= 16'd0;
            waddr_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 8'd0;
            ram_we_q    <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            case (state_q)
                LEN_LO: begin
                    if (hs_s) len_q[7:0] <= s_if.in_data;
                end
                LEN_HI: begin
                    if (hs_s) begin
                        len_q[15:8] <= s_if.in_data;
                        cnt_q       <= len_hdr_s;
                        waddr_q     <= '0;
                    end
                end
                LOAD: begin
                    if (hs_s && wr_ok_s) begin
                        ram_we_q    <= 1'b1;
                        ram_wdata_q <= s_if.in_data;
                        ram_addr_q  <= waddr_q[ADDR_W-1:0];
                        waddr_q     <= waddr_q + (ADDR_W+1)'(1);
                        cnt_q       <= cnt_q - 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/ram_init_ctrl.md
RAM_INIT_CTRL -- requirements
Module: ram_init_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving the RAM address width.
REQ-002 SHALL have parameter DEPTH, default 1024, giving the maximum loadable bytes; DEPTH SHALL be at most 2**ADDR_W.
REQ-003 SHALL have port clk, input, 1 bit: clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle load-request pulse.
REQ-006 SHALL have port in_valid, input, 1 bit: the byte stream has valid data.
REQ-007 SHALL have port in_data, input, 8 bits: stream byte.
REQ-008 SHALL have port in_ready, output, 1 bit: the controller accepts the stream byte.
REQ-009 SHALL have port cpu_addr, input, ADDR_W bits: CPU read address.
REQ-010 SHALL have port cpu_gnt, output, 1 bit: the CPU owns the RAM port.
REQ-011 SHALL have port ram_we, output, 1 bit: RAM write strobe.
REQ-012 SHALL have port ram_addr, output, ADDR_W bits: RAM address.
REQ-013 SHALL have port ram_wdata, output, 8 bits: RAM write data.
REQ-014 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-015 SHALL have port done, output, 1 bit: the image is loaded.
REQ-016 SHALL have port err, output, 1 bit: the length header exceeded DEPTH.

Function
REQ-017 SHALL implement FSM states IDLE, LEN_LO, LEN_HI, LOAD, FLUSH, DONE, ERROR.
REQ-018 Handshake SHALL occur in a cycle where in_valid=1 and in_ready=1; in_ready SHALL be 1 only in LEN_LO, LEN_HI and LOAD.
REQ-019 IDLE: start=1 SHALL move to LEN_LO; otherwise stay.
REQ-020 LEN_LO: on handshake, in_data SHALL be latched as len[7:0], then move to LEN_HI.
REQ-021 LEN_HI: on handshake, in_data SHALL be latched as len[15:8], then the next state SHALL be selected as follows.
- len==0 -> FLUSH.
- len>DEPTH (compared at 17 bits) -> ERROR.
- Otherwise -> LOAD, with write address 0 and remaining count set to len.
REQ-022 LOAD: each handshake in cycle N SHALL produce registered ram_we=1, ram_wdata=in_data and ram_addr=current write address in cycle N+1.
- The write address SHALL then increment and the remaining count decrement.
- A stall (in_valid=0) SHALL produce ram_we=0 with no counter change.
REQ-023 LOAD: the handshake that brings the remaining count to 0 SHALL move to FLUSH; no further byte SHALL be accepted in that load.
REQ-024 FLUSH SHALL last exactly one cycle, completing any pending write strobe, then move to DONE.
REQ-025 DONE: done=1, cpu_gnt=1, ram_we=0, and ram_addr SHALL equal cpu_addr combinationally.
REQ-026 In all states other than DONE, cpu_gnt SHALL be 0 and ram_addr SHALL be the registered loader address.
REQ-027 ERROR: err=1, in_ready=0, ram_we=0; the FSM SHALL stay in ERROR until start or reset.
REQ-028 start=1 in DONE or ERROR SHALL move to LEN_LO next cycle, clearing done, err and cpu_gnt.
REQ-029 start=1 in LEN_LO, LEN_HI, LOAD or FLUSH SHALL be ignored.
REQ-030 busy SHALL be 1 exactly in LEN_LO, LEN_HI, LOAD and FLUSH.
REQ-031 ram_we SHALL never be 1 in the same cycle as cpu_gnt.
REQ-032 A len of exactly DEPTH SHALL be legal; the last write SHALL go to address DEPTH-1, and the write address SHALL never wrap within a load.

Reset
REQ-033 reset=1 SHALL asynchronously force the following, aborting any load in progress.
- State IDLE.
- busy, done, err, cpu_gnt, ram_we and in_ready all 0.
- ram_addr, ram_wdata, len, write address and remaining count all 0.
REQ-034 After reset deassertion, the first action SHALL require a new start pulse.

Verification
REQ-035 start; stream 03 00 AA BB CC, in_valid held high -> writes AA@0, BB@1, CC@2 on consecutive cycles; FLUSH; done=1 and cpu_gnt=1 after the FLUSH cycle.
REQ-036 start; 02 00 11 with a 3-cycle in_valid gap, then 22 -> ram_we=0 during the gap, 11@0, 22@1, then done=1.
REQ-037 start; length header 01 04 (len=1025) with DEPTH=1024 -> ERROR, err=1, in_ready=0, no ram_we; then start; 00 00 -> done=1 with no writes.
REQ-038 start; length header 00 04 (len=1024) -> last write at address 1023, no wrap, then done=1.
REQ-039 reset pulsed mid-LOAD after 5 of 10 bytes -> all outputs 0 immediately; a subsequent start and full stream reload from address 0.
REQ-040 In DONE, drive cpu_addr=0x155 -> ram_addr=0x155 in the same cycle; start pulse -> cpu_gnt=0 next cycle, busy=1.
